// File: rtl/sudoku_pkg.sv
// sudoku_pkg: shared constants and scan state encoding for the Sudoku group logic
package sudoku_pkg;
  localparam int DIGITS = 9;
  localparam logic [1:0] ADDR_VALUE  = 2'd0;
  localparam logic [1:0] ADDR_PENCIL = 2'd1;
  localparam logic [1:0] ADDR_VALID  = 2'd2;
  typedef enum logic [2:0] {IDLE, READ, APPLY, SINGLE, DONE} scan_state_t;
endpackage

// File: rtl/sudoku_digit_check.sv
// sudoku_digit_check: classifies a digit bus value against a mask of used digits
module sudoku_digit_check
  import sudoku_pkg::*;
(
  input  logic [DIGITS:1] v,
  input  logic [DIGITS:1] mask,
  output logic            is_zero,
  output logic            is_onehot,
  output logic            dup
);
  assign is_zero   = v == '0;
  assign is_onehot = $onehot(v);
  assign dup       = |(v & mask);
endmodule

// File: rtl/sudoku_group_scan.sv
// sudoku_group_scan: reads nine cells, builds the used-digit mask, then prunes and resolves singletons
module sudoku_group_scan
  import sudoku_pkg::*;
#(
  parameter bit SINGLE_EN_DEFAULT = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              single_en,
  output logic              busy,
  output logic              done,
  output logic              conflict,
  output logic              group_solved,
  output logic [DIGITS-1:0] used_mask,
  output logic [DIGITS-1:0] cell_oe,
  output logic [1:0]        address,
  output logic              latch_valid,
  output logic              latch_singleton,
  inout  wire  [DIGITS-1:0] value_io
);
  scan_state_t       state;
  logic              drive;
  logic              is_zero, is_onehot, dup;
  logic              conf_next;
  logic [DIGITS-1:0] mask_next;

  sudoku_digit_check u_check (
    .v        (value_io),
    .mask     (used_mask),
    .is_zero  (is_zero),
    .is_onehot(is_onehot),
    .dup      (dup)
  );

  assign conf_next = conflict | (is_onehot & dup) | (!is_zero & !is_onehot);
  assign mask_next = is_onehot ? used_mask | value_io : used_mask;
  assign address   = ADDR_VALUE;
  assign value_io  = drive ? ~used_mask : {DIGITS{1'bz}};

  // scan sequencer: walks the one-hot read enable, then prune and singleton strobes
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      busy            <= 1'b0;
      done            <= 1'b0;
      conflict        <= 1'b0;
      group_solved    <= 1'b0;
      used_mask       <= '0;
      cell_oe         <= '0;
      latch_valid     <= 1'b0;
      latch_singleton <= 1'b0;
      drive           <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state     <= READ;
          busy      <= 1'b1;
          cell_oe   <= DIGITS'(1);
          used_mask <= '0;
          conflict  <= 1'b0;
        end
        READ: begin
          used_mask <= mask_next;
          conflict  <= conf_next;
          cell_oe   <= cell_oe << 1;
          if (cell_oe[DIGITS-1]) begin
            state       <= conf_next ? DONE : APPLY;
            drive       <= !conf_next;
            latch_valid <= !conf_next;
            done        <= conf_next;
            if (conf_next) group_solved <= mask_next == '1;
          end
        end
        APPLY: begin
          drive           <= 1'b0;
          latch_valid     <= 1'b0;
          latch_singleton <= single_en;
          done            <= !single_en;
          state           <= single_en ? SINGLE : DONE;
          if (!single_en) group_solved <= used_mask == '1;
        end
        SINGLE: begin
          latch_singleton <= 1'b0;
          done            <= 1'b1;
          group_solved    <= used_mask == '1;
          state           <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sudoku_group_scan.sv
// tb_sudoku_group_scan: directed scans against nine modelled cells on the shared bus
module tb_sudoku_group_scan;
  logic       clk = 1'b0;
  logic       reset_n, start, single_en, probe;
  logic       busy, done, conflict, group_solved, latch_valid, latch_singleton;
  logic [8:0] used_mask, cell_oe, sel;
  logic [1:0] address;
  wire  [8:0] value_io;
  logic [8:0] cells [9];
  int         errors = 0, checks = 0, viol = 0;
  int         lv_c, ls_c, dn_c, dn_n, bl_c;
  logic [8:0] lv_bus;

  sudoku_group_scan dut (
    .clk(clk), .reset_n(reset_n), .start(start), .single_en(single_en),
    .busy(busy), .done(done), .conflict(conflict), .group_solved(group_solved),
    .used_mask(used_mask), .cell_oe(cell_oe), .address(address),
    .latch_valid(latch_valid), .latch_singleton(latch_singleton), .value_io(value_io)
  );

  always #5 clk = ~clk;

  // cells drive combinationally when enabled; probe drives zeros to expose any stray DUT drive
  always_comb begin
    sel = '0;
    for (int k = 0; k < 9; k++) if (cell_oe[k]) sel = cells[k];
  end
  assign value_io = (|cell_oe || probe) ? (probe ? 9'h000 : sel) : 9'bz;

  // bus exclusivity monitor
  always @(negedge clk) if (reset_n) begin
    if ((cell_oe & (cell_oe - 9'd1)) != 9'd0) viol++;
    if (latch_valid && cell_oe != 9'd0) viol++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] oh(input int d);
    return d == 0 ? 9'h000 : 9'(1) << (d - 1);
  endfunction

  task automatic load(input int d0, d1, d2, d3, d4, d5, d6, d7, d8);
    cells = '{oh(d0), oh(d1), oh(d2), oh(d3), oh(d4), oh(d5), oh(d6), oh(d7), oh(d8)};
  endtask

  task automatic kick(input logic se);
    @(negedge clk);
    start = 1'b1;
    single_en = se;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic scan(input logic se, input int pulse_at);
    kick(se);
    lv_c = 0; ls_c = 0; dn_c = 0; dn_n = 0; bl_c = 0; lv_bus = 'x;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      start = (c == pulse_at);
      if (latch_valid) begin lv_c = c; lv_bus = value_io; end
      if (latch_singleton) ls_c = c;
      if (done) begin dn_c = c; dn_n++; end
      if (!busy && bl_c == 0 && dn_n > 0) bl_c = c;
    end
    start = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; single_en = 1'b0; probe = 1'b1;
    load(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_conflict", conflict, 0);
    check("rst_solved", group_solved, 0);
    check("rst_mask", used_mask, 0);
    check("rst_oe", cell_oe, 0);
    check("rst_addr", address, 0);
    check("rst_lv", latch_valid, 0);
    check("rst_ls", latch_singleton, 0);
    check("rst_bus", value_io, 0);
    probe = 1'b0;
    reset_n = 1'b1;

    load(1, 0, 3, 0, 0, 6, 0, 0, 9);
    scan(1'b1, 0);
    check("t1_mask", used_mask, 9'h125);
    check("t1_lv_cycle", lv_c, 10);
    check("t1_lv_bus", lv_bus, 9'h0DA);
    check("t1_ls_cycle", ls_c, 11);
    check("t1_done_cycle", dn_c, 12);
    check("t1_busy_low", bl_c, 13);
    check("t1_conflict", conflict, 0);
    check("t1_solved", group_solved, 0);

    load(0, 0, 5, 0, 0, 0, 0, 5, 0);
    scan(1'b1, 0);
    check("t2_conflict", conflict, 1);
    check("t2_lv", lv_c, 0);
    check("t2_ls", ls_c, 0);
    check("t2_done_cycle", dn_c, 10);
    check("t2_mask", used_mask, 9'h010);

    load(9, 0, 0, 0, 0, 0, 0, 0, 0);
    cells[4] = 9'h003;
    scan(1'b1, 0);
    check("t3_conflict", conflict, 1);
    check("t3_done_cycle", dn_c, 10);
    check("t3_mask", used_mask, 9'h100);

    load(1, 2, 3, 4, 5, 6, 7, 8, 9);
    scan(1'b0, 0);
    check("t4_solved", group_solved, 1);
    check("t4_conflict", conflict, 0);
    check("t4_lv_cycle", lv_c, 10);
    check("t4_lv_bus", lv_bus, 9'h000);
    check("t4_ls", ls_c, 0);
    check("t4_done_cycle", dn_c, 11);

    load(1, 0, 3, 0, 0, 6, 0, 0, 9);
    kick(1'b1);
    repeat (5) @(negedge clk);
    check("t5_oe_idx4", cell_oe, 9'h010);
    reset_n = 1'b0;
    probe = 1'b1;
    #1;
    check("t5_oe", cell_oe, 0);
    check("t5_busy", busy, 0);
    check("t5_lv", latch_valid, 0);
    check("t5_solved", group_solved, 0);
    check("t5_bus", value_io, 0);
    probe = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    scan(1'b1, 0);
    check("t5_mask", used_mask, 9'h125);
    check("t5_done_cycle", dn_c, 12);

    load(0, 4, 0, 2, 0, 0, 8, 0, 0);
    scan(1'b1, 4);
    check("t6_done_count", dn_n, 1);
    check("t6_done_cycle", dn_c, 12);
    check("t6_mask", used_mask, 9'h08A);
    check("t6_bus_excl", viol, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
